drive_cmd_uart_tx: RTL and testbench

//  Far end of the manual-driving control word: samples the live drive command
//  (bf, turn, power) and serialises it as an 8N1 UART byte to the car simulator.

---
 rtl/drive_cmd_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_drive_cmd_uart_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/drive_cmd_uart_tx.sv
// drive_cmd_uart_tx
//   Serialises the live drive command {bf, tlr, power} as an 8N1 UART byte for
//   the car simulator. A byte goes out whenever the command changes, and the
//   last byte is re-sent as a keep-alive after REFRESH_CYCLES quiet idle cycles.
//   Byte layout: {3'b010, power, tlr[1], tlr[0], bf[1], bf[0]}. An illegal
//   bf of 11 is sent as 00.
//
//   Optional feature: define PARITY_EN to append an even-parity bit after data
//   bit 7, which makes the frame 11 bit times instead of 10.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous active-high reset
//   bf[1:0]     in   motion: 01 forward, 10 backward, 00 none, 11 illegal
//   tlr[1:0]    in   turn: bit0 left, bit1 right
//   power       in   1 = engine on
//   tx          out  UART serial line, idle high
//   busy        out  high from start bit through stop bit
//   frame_done  out  1-cycle pulse in the last cycle of the stop bit
//   illegal     out  1-cycle pulse when a frame is loaded with bf == 11
module drive_cmd_uart_tx #(
    parameter int unsigned CLKS_PER_BIT   = 10417,
    parameter int unsigned REFRESH_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bf,
    input  logic [1:0] tlr,
    input  logic       power,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       illegal
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Input stage {power, tlr, bf}. Deliberately not reset: it keeps sampling
    // while rst is held, so the first frame after release carries the live inputs.
    logic [4:0] cmd_q;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        last_sent_q, last_sent_d;
    logic              pending_q, pending_d;
    logic [REF_W-1:0]  refresh_q, refresh_d;

    logic [7:0] cmd_byte;
    logic       bit_end;
    logic       load;
    logic       ref_hit;

    always_ff @(posedge clk) begin
        cmd_q <= {power, tlr, bf};
    end

    assign cmd_byte = {3'b010, cmd_q[4], cmd_q[3:2],
                       (cmd_q[1:0] == 2'b11) ? 2'b00 : cmd_q[1:0]};
    assign bit_end  = (baud_q == BAUD_LAST);
    assign load     = (state_q == ST_IDLE) && pending_q;
    assign ref_hit  = (refresh_q == REF_LAST);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        last_sent_d = last_sent_q;
        refresh_d   = refresh_q;
        // Not sticky during a frame: a change that reverts before the frame
        // ends must not cause an extra frame.
        pending_d   = (cmd_byte != last_sent_q);
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (pending_q) begin
                    shift_d     = cmd_byte;
                    last_sent_d = cmd_byte;
                    pending_d   = 1'b0;
                    refresh_d   = '0;
                    state_d     = ST_START;
                end else if (ref_hit) begin
                    pending_d = 1'b1;
                end else begin
                    refresh_d = refresh_q + 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            last_sent_q <= 8'h00;
            pending_q   <= 1'b1;
            refresh_q   <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
            refresh_q   <= refresh_d;
        end
    end

    // tx decodes registered state only, so an asynchronous reset idles the line at once.
    // last_sent_q cannot change mid-frame, so it doubles as the parity source.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_q[0];
`ifdef PARITY_EN
            ST_PARITY: tx = ^last_sent_q;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_STOP) && bit_end;
    assign illegal    = load && (cmd_q[1:0] == 2'b11);

endmodule

// File: tb/tb_drive_cmd_uart_tx.sv
// tb_drive_cmd_uart_tx
//   Directed bench for drive_cmd_uart_tx with CLKS_PER_BIT=4, REFRESH_CYCLES=200.
//   Outputs are sampled on the falling clock edge; inputs change there too.
module tb_drive_cmd_uart_tx;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] bf;
    logic [1:0] tlr;
    logic       power;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       illegal;

    int compared   = 0;
    int mismatched = 0;
    int cyc;

    drive_cmd_uart_tx #(
        .CLKS_PER_BIT   (4),
        .REFRESH_CYCLES (200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bf         (bf),
        .tlr        (tlr),
        .power      (power),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until tx goes low, up to bound.
    task automatic wait_start(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (tx !== 1'b0 && cycles < bound);
    endtask

    // Called on the falling edge of the first start-bit cycle. Checks every
    // cycle of the frame and the idle cycle after it. Optionally changes tlr
    // to tlr_a at cycle chg_at and to tlr_b eight cycles later.
    task automatic capture(input string tag, input logic [7:0] exp, input int chg_at,
                           input logic [1:0] tlr_a, input logic [1:0] tlr_b);
        logic [10:0] fbits;
        logic [7:0]  data;
        int errs, bad_busy, fd_cnt, fd_pos;
        fbits    = '1;
        fbits[0] = 1'b0;
        fbits[8:1] = exp;
`ifdef PARITY_EN
        fbits[9] = ^exp;
`endif
        data = '0;
        errs = 0; bad_busy = 0; fd_cnt = 0; fd_pos = -1;
        for (int c = 0; c < FL; c++) begin
            if (c > 0) @(negedge clk);
            if (chg_at >= 0 && c == chg_at) tlr = tlr_a;
            if (chg_at >= 0 && c == chg_at + 8) tlr = tlr_b;
            if (tx !== fbits[c / CPB]) errs++;
            if (busy !== 1'b1) bad_busy++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_pos = c;
            end
            if ((c % CPB) == 1 && (c / CPB) >= 1 && (c / CPB) <= 8) data[c / CPB - 1] = tx;
        end
        check({tag, " byte"}, 32'(data), 32'(exp));
        check({tag, " bit errors"}, errs, 0);
        check({tag, " busy gaps"}, bad_busy, 0);
        check({tag, " frame_done count"}, fd_cnt, 1);
        check({tag, " frame_done pos"}, fd_pos, FL - 1);
        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 0);
        check({tag, " idle tx"}, 32'(tx), 1);
        check({tag, " idle frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        rst = 1'b1; bf = 2'b00; tlr = 2'b00; power = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 1);
        check("reset busy", 32'(busy), 0);
        check("reset frame_done", 32'(frame_done), 0);
        check("reset illegal", 32'(illegal), 0);

        // 1: first frame after reset release
        rst = 1'b0;
        wait_start(5, cyc);
        check("t1 start latency", cyc, 1);
        capture("t1", 8'h40, -1, 2'b00, 2'b00);

        // 2: forward + power while idle, tx falls two edges after sampling
        bf = 2'b01; power = 1'b1;
        wait_start(10, cyc);
        check("t2 start latency", cyc, 3);
        // 3: tlr changes during the 0x51 frame, only the final value is sent
        capture("t2", 8'h51, 8, 2'b01, 2'b10);
        wait_start(5, cyc);
        check("t3 start gap", cyc, 1);
        capture("t3", 8'h59, -1, 2'b00, 2'b00);

        // 4: keep-alive refresh, then a change that reverts mid-frame
        wait_start(300, cyc);
        check("t4 refresh delay", cyc, 201);
        capture("t4", 8'h59, 8, 2'b01, 2'b10);
        expect_quiet("t4 no extra frame", 50);

        // 5: illegal bf
        bf = 2'b11; tlr = 2'b00; power = 1'b1;
        @(negedge clk);
        check("t5 illegal early", 32'(illegal), 0);
        @(negedge clk);
        check("t5 illegal pulse", 32'(illegal), 1);
        check("t5 tx before start", 32'(tx), 1);
        @(negedge clk);
        check("t5 illegal cleared", 32'(illegal), 0);
        check("t5 start bit", 32'(tx), 0);
        capture("t5", 8'h50, -1, 2'b00, 2'b00);

        // 6: reset during data bit 3
        bf = 2'b01; tlr = 2'b00; power = 1'b1;
        wait_start(10, cyc);
        check("t6 start latency", cyc, 3);
        repeat (17) @(negedge clk);
        check("t6 data bit 3", 32'(tx), 0);
        #1 rst = 1'b1;
        #1;
        check("t6 async tx", 32'(tx), 1);
        check("t6 async busy", 32'(busy), 0);
        check("t6 async frame_done", 32'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_start(5, cyc);
        check("t6 restart latency", cyc, 1);
        capture("t6", 8'h51, -1, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
